// File: rtl/serial_subtractor_cell.sv
// +--------------------------------------------------------------+
// | Full_Subtractor: one-bit full subtractor, diff = a - b - cin  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module Full_Subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ cin;
  assign borrow = (~a & b) | (~a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +--------------------------------------------------------------+
// | serial_subtractor: LSB-first bit-serial a - b - bin          |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             cell_diff;
  logic             cell_borrow;

  Full_Subtractor u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .cin    (borrow_q),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            d_sr     <= '0;
            borrow_q <= bin_in;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so d_sr is aligned after WIDTH shifts.
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          d_sr     <= {cell_diff, d_sr[WIDTH-1:1]};
          borrow_q <= cell_borrow;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff_out   = d_sr;
  assign borrow_out = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +--------------------------------------------------------------+
// | tb_serial_subtractor: random/directed bench vs. a-b-bin model |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin_in     (bin_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer difference; negative means a borrow out.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic bin);
    longint r;
    longint m;
    logic [WIDTH:0] res;
    m = longint'(1) << WIDTH;
    r = longint'(a) - longint'(b) - longint'(bin);
    res[WIDTH]     = (r < 0);
    res[WIDTH-1:0] = WIDTH'((r + m) % m);
    return res;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input int stall);
    logic [WIDTH:0]   e;
    int               n;
    logic [WIDTH-1:0] d0;
    logic             b0;
    e = ref_sub(a, b, bin);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a_in = a; b_in = b; bin_in = bin; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); bin_in = 1'($urandom);
    check("in_ready_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 4 * WIDTH) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, WIDTH);
    check("diff", diff_out, e[WIDTH-1:0]);
    check("borrow", borrow_out, e[WIDTH]);
    d0 = diff_out;
    b0 = borrow_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_diff", diff_out, d0);
      check("stall_borrow", borrow_out, b0);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_diff_hold", diff_out, d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH:0] e;
    logic [WIDTH:0] exp_q[$];
    int             last_acc;
    int             accepts;
    int             bad;

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff_out, 0);
    check("rst_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h10, 1'b1, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'hC3, 8'h77, 1'b0, 5);
    for (int i = 0; i < 4; i++) run_op(WIDTH'($urandom), 8'hFF, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      e[WIDTH-1:0] = WIDTH'($urandom);
      run_op(e[WIDTH-1:0], e[WIDTH-1:0], 1'b0, 0);
    end

    // in_valid held high with fresh operands every cycle.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; accepts = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); bin_in = 1'($urandom);
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cont_diff", diff_out, e[WIDTH-1:0]);
          check("cont_borrow", borrow_out, e[WIDTH]);
        end else begin
          check("cont_spurious_out", 1, 0);
        end
      end
      if (in_ready) begin
        exp_q.push_back(ref_sub(a_in, b_in, bin_in));
        if (last_acc >= 0) check("accept_gap", cyc - last_acc, WIDTH + 2);
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 3 * WIDTH; cyc++) begin
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("drain_diff", diff_out, e[WIDTH-1:0]);
        check("drain_borrow", borrow_out, e[WIDTH]);
      end
      @(negedge clk);
    end
    check("cont_pending", exp_q.size(), 0);
    check("cont_accepts_min", accepts >= 5, 1);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    a_in = 8'hA5; b_in = 8'h3C; bin_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_diff", diff_out, 0);
    check("midrun_rst_borrow", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midrun_rst_no_valid", bad, 0);
    run_op(8'h33, 8'h34, 1'b0, 2);

    for (int i = 0; i < 1000; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor built around the team's one-bit full-subtractor cell. It accepts a WIDTH-bit operand pair and a borrow-in over a valid/ready handshake. It feeds the cell LSB-first, one bit per clock, and carries the borrow between bits in a register. It returns diff = a - b - bin (mod 2^WIDTH) plus the final borrow on an output valid/ready handshake. It is the stage that drives the full-subtractor cell and consumes its diff/borrow outputs.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), width of the bit counter (derived; do not override)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  block can accept an operand pair
a_in  in  WIDTH  minuend
b_in  in  WIDTH  subtrahend
bin_in  in  1  borrow-in (for chaining wider subtractions)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
diff_out  out  WIDTH  a_in - b_in - bin_in, mod 2^WIDTH
borrow_out  out  1  1 when a_in < b_in + bin_in (unsigned)

Behaviour:
- Reset (async, active-high): state = IDLE; a_sr, b_sr, d_sr = 0; borrow_q = 0; cnt = 0.
- Outputs during and after reset: in_ready = 1, out_valid = 0, diff_out = 0, borrow_out = 0.
- FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from state only; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load a_sr = a_in, b_sr = b_in, borrow_q = bin_in, cnt = 0, d_sr = 0, then go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - The cell is driven with a = a_sr[0], b = b_sr[0], cin = borrow_q.
  - Each edge: a_sr and b_sr shift right by 1; d_sr shifts right with the cell diff inserted at the MSB; borrow_q takes the cell borrow; cnt increments.
  - When cnt == WIDTH-1 on an edge: perform that final shift, then go to DONE.
- DONE:
  - out_valid = 1; diff_out = d_sr; borrow_out = borrow_q.
  - Outputs stay stable while out_ready = 0, with no timeout.
  - On out_ready: go to IDLE. diff_out and borrow_out hold their last values; they are only meaningful while out_valid = 1.
- Timing:
  - Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
  - Minimum initiation interval: WIDTH + 2 cycles. There is no overlap: in_ready is 0 in DONE, including the cycle of the output handshake.
- Width rule: result = (a + 2^WIDTH - b - bin) truncated to WIDTH bits; borrow_out is the inverted bit WIDTH of that sum.
- Boundary conditions:
  - bin_in = 1 with b_in = all-ones: borrow_out = 1 for any a_in.
  - Equal operands with bin_in = 0: diff 0, borrow 0.
  - rst asserted mid-RUN or in DONE: the operation is abandoned immediately, all state returns to reset values, and no out_valid pulse follows.
  - in_valid held high through RUN/DONE does not start a second operation until the state is back in IDLE.
  - cnt never exceeds WIDTH-1.

Decomposition:
- No shared package needed. State encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) are localparams inside the module.
- One sub-module: the existing Full_Subtractor cell, instantiated once (ports a, b, cin, diff, borrow).
- Shift registers, counter and FSM are in this module.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, out_ready=1 -> out_valid exactly 8 edges after accept; diff=0x1E, borrow=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1; a=0x10, b=0x10, bin=1 -> diff=0xFF, borrow=1; a=0xFF, b=0x00, bin=1 -> diff=0xFE, borrow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, diff_out and borrow_out stable; in_ready=0 throughout. Release -> IDLE next edge, in_ready=1.
- in_valid held high continuously with changing operands -> exactly one accept per WIDTH+2 cycles; each result matches the operands sampled at its accept edge.
- Assert rst at RUN cycle 3 -> outputs return to reset values asynchronously, no out_valid. A new op after release gives the correct result.
- Random sweep of 1000 (a, b, bin) triples with random out_ready stalls -> all results match the a-b-bin reference model, including borrow.
